// File: rtl/mouse_axis_pkg.sv
// Shared types for the PS/2-mouse-to-analog-axis emulator: mode enum,
// mouse packet layout and status-byte bit positions.
package mouse_axis_pkg;

    typedef enum logic {
        JOY   = 1'b0,
        MOUSE = 1'b1
    } mode_t;

    typedef struct packed {
        logic       strobe;
        logic [7:0] dy;
        logic [7:0] dx;
        logic [7:0] status;
    } ps2_mouse_t;

    localparam int BTN_L  = 0;
    localparam int BTN_R  = 1;
    localparam int X_SIGN = 4;
    localparam int Y_SIGN = 5;
    localparam int X_OVF  = 6;
    localparam int Y_OVF  = 7;

endpackage

// File: rtl/mouse_axis_if.sv
// Bundle of mouse, real-joystick and selected-axis signals between hps_io
// and the core's joystick ports. The emulator uses the slave side.
interface mouse_axis_if #(
    parameter int AXIS_W = 8
);
    import mouse_axis_pkg::*;

    ps2_mouse_t               ps2_mouse;
    logic                     mouse_en;
    logic                     sync_clear;
    logic signed [AXIS_W-1:0] joy_x;
    logic signed [AXIS_W-1:0] joy_y;
    logic                     joy_fire;
    logic                     joy_active;
    logic signed [AXIS_W-1:0] axis_x;
    logic signed [AXIS_W-1:0] axis_y;
    logic                     fire;
    logic                     emu_active;

    modport master (
        output ps2_mouse, mouse_en, sync_clear, joy_x, joy_y, joy_fire, joy_active,
        input  axis_x, axis_y, fire, emu_active
    );

    modport slave (
        input  ps2_mouse, mouse_en, sync_clear, joy_x, joy_y, joy_fire, joy_active,
        output axis_x, axis_y, fire, emu_active
    );

endinterface

// File: rtl/mouse_axis_accum.sv
// One axis: overflow substitution and clamp of the packet delta (stage 1),
// then saturating accumulate / recentre of the axis position (stage 2).
module mouse_axis_accum #(
    parameter int AXIS_W   = 8,
    parameter int MAX_STEP = 10,
    parameter bit NEG      = 1'b0
) (
    input  logic                     clk_sys,
    input  logic                     hard_reset_n,
    input  logic                     i_cap,
    input  logic [7:0]               i_delta,
    input  logic                     i_sign,
    input  logic                     i_ovf,
    input  logic                     i_clear,
    input  logic                     i_upd,
    input  logic                     i_recentre,
    output logic signed [AXIS_W-1:0] o_acc
);
    // Sum width is AXIS_W+2, but never narrower than a sign-extended 9-bit step.
    localparam int SW = (AXIS_W + 2 > 10) ? AXIS_W + 2 : 10;
    localparam logic signed [8:0]    STEP_HI = 9'(MAX_STEP);
    localparam logic signed [8:0]    STEP_LO = 9'(-MAX_STEP);
    localparam logic signed [SW-1:0] SAT_HI  = SW'((64'sd1 <<< (AXIS_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_LO  = ~SAT_HI;

    logic signed [8:0]    w_ext;
    logic signed [8:0]    w_step;
    logic signed [8:0]    r_step;
    logic signed [SW-1:0] w_acc;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_sat;

    always_comb begin
        w_ext = {i_sign, i_delta};
        if (i_ovf)
            w_step = i_sign ? STEP_LO : STEP_HI;
        else if (w_ext > STEP_HI)
            w_step = STEP_HI;
        else if (w_ext < STEP_LO)
            w_step = STEP_LO;
        else
            w_step = w_ext;

        w_acc = SW'(o_acc);
        w_sum = NEG ? (w_acc - SW'(r_step)) : (w_acc + SW'(r_step));
        if (w_sum > SAT_HI)
            w_sat = SAT_HI;
        else if (w_sum < SAT_LO)
            w_sat = SAT_LO;
        else
            w_sat = w_sum;
    end

    always_ff @(posedge clk_sys or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            r_step <= '0;
            o_acc  <= '0;
        end else begin
            if (i_cap)
                r_step <= w_step;
            if (i_clear)
                o_acc <= '0;
            else if (i_upd)
                o_acc <= AXIS_W'(w_sat);
            else if (i_recentre && (o_acc != '0))
                o_acc <= o_acc[AXIS_W-1] ? (o_acc + AXIS_W'(1)) : (o_acc - AXIS_W'(1));
        end
    end

endmodule

// File: rtl/mouse_axis_emu.sv
// PS/2 mouse to saturating analog axes, muxed with the real joystick.
// Optional idle recentring is enabled by defining MOUSE_AXIS_RECENTRE_EN.
module mouse_axis_emu
    import mouse_axis_pkg::*;
#(
    parameter int AXIS_W   = 8,
    parameter int MAX_STEP = 10,
    parameter int INVERT_Y = 1
`ifdef MOUSE_AXIS_RECENTRE_EN
    ,
    parameter int RECENTRE_PERIOD = 65536
`endif
) (
    input logic           clk_sys,
    input logic           hard_reset_n,
    mouse_axis_if.slave   bus
);
    ps2_mouse_t               w_pkt;
    logic                     w_clear;
    logic                     w_zero;
    logic                     w_new;
    logic                     w_recentre;
    logic signed [AXIS_W-1:0] w_acc_x;
    logic signed [AXIS_W-1:0] w_acc_y;
    logic                     w_unused;

    mode_t                    r_mode;
    logic                     r_strobe;
    logic                     r_s0_valid;
    logic [7:0]               r_s0_dx;
    logic [7:0]               r_s0_dy;
    logic [7:0]               r_s0_st;
    logic                     r_s1_valid;
    logic [1:0]               r_s1_btn;
    logic                     r_fire_m;
    logic signed [AXIS_W-1:0] r_joy_x;
    logic signed [AXIS_W-1:0] r_joy_y;
    logic                     r_joy_fire;

    assign w_pkt    = bus.ps2_mouse;
    assign w_clear  = bus.sync_clear | ~bus.mouse_en;
    assign w_zero   = w_clear | bus.joy_active;
    assign w_new    = w_pkt.strobe ^ r_strobe;
    assign w_unused = &{1'b0, r_s0_st[3:2]};

    // The strobe copy always follows the input, so a packet dropped by a clear is consumed.
    always_ff @(posedge clk_sys or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            r_strobe   <= 1'b0;
            r_s0_valid <= 1'b0;
            r_s0_dx    <= '0;
            r_s0_dy    <= '0;
            r_s0_st    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_btn   <= '0;
            r_fire_m   <= 1'b0;
            r_joy_x    <= '0;
            r_joy_y    <= '0;
            r_joy_fire <= 1'b0;
        end else begin
            r_strobe   <= w_pkt.strobe;
            r_s0_valid <= w_new & ~w_clear;
            if (w_new) begin
                r_s0_dx <= w_pkt.dx;
                r_s0_dy <= w_pkt.dy;
                r_s0_st <= w_pkt.status;
            end
            r_s1_valid <= r_s0_valid & ~w_clear;
            if (r_s0_valid)
                r_s1_btn <= {r_s0_st[BTN_R], r_s0_st[BTN_L]};
            if (w_zero)
                r_fire_m <= 1'b0;
            else if (r_s1_valid)
                r_fire_m <= |r_s1_btn;
            r_joy_x    <= bus.joy_x;
            r_joy_y    <= bus.joy_y;
            r_joy_fire <= bus.joy_fire;
        end
    end

    always_ff @(posedge clk_sys or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            r_mode <= JOY;
        end else begin
            case (r_mode)
                JOY:     if (r_s1_valid && !w_zero) r_mode <= MOUSE;
                MOUSE:   if (w_zero) r_mode <= JOY;
                default: r_mode <= JOY;
            endcase
        end
    end

`ifdef MOUSE_AXIS_RECENTRE_EN
    localparam int CNT_W = (RECENTRE_PERIOD > 1) ? $clog2(RECENTRE_PERIOD) : 1;
    logic [CNT_W-1:0] r_idle;

    assign w_recentre = (r_mode == MOUSE) && !r_s1_valid &&
                        (r_idle == CNT_W'(RECENTRE_PERIOD - 1));

    always_ff @(posedge clk_sys or negedge hard_reset_n) begin
        if (!hard_reset_n)
            r_idle <= '0;
        else if ((r_mode != MOUSE) || r_s1_valid || w_recentre)
            r_idle <= '0;
        else
            r_idle <= r_idle + CNT_W'(1);
    end
`else
    assign w_recentre = 1'b0;
`endif

    mouse_axis_accum #(.AXIS_W(AXIS_W), .MAX_STEP(MAX_STEP), .NEG(1'b0)) u_acc_x (
        .clk_sys      (clk_sys),
        .hard_reset_n (hard_reset_n),
        .i_cap        (r_s0_valid),
        .i_delta      (r_s0_dx),
        .i_sign       (r_s0_st[X_SIGN]),
        .i_ovf        (r_s0_st[X_OVF]),
        .i_clear      (w_zero),
        .i_upd        (r_s1_valid),
        .i_recentre   (w_recentre),
        .o_acc        (w_acc_x)
    );

    mouse_axis_accum #(.AXIS_W(AXIS_W), .MAX_STEP(MAX_STEP), .NEG(INVERT_Y != 0)) u_acc_y (
        .clk_sys      (clk_sys),
        .hard_reset_n (hard_reset_n),
        .i_cap        (r_s0_valid),
        .i_delta      (r_s0_dy),
        .i_sign       (r_s0_st[Y_SIGN]),
        .i_ovf        (r_s0_st[Y_OVF]),
        .i_clear      (w_zero),
        .i_upd        (r_s1_valid),
        .i_recentre   (w_recentre),
        .o_acc        (w_acc_y)
    );

    assign bus.axis_x     = (r_mode == MOUSE) ? w_acc_x : r_joy_x;
    assign bus.axis_y     = (r_mode == MOUSE) ? w_acc_y : r_joy_y;
    assign bus.fire       = (r_mode == MOUSE) ? r_fire_m : r_joy_fire;
    assign bus.emu_active = (r_mode == MOUSE);

endmodule

// File: tb/tb_mouse_axis_emu.sv
// Directed bench for mouse_axis_emu: latency, clamp, overflow, saturation,
// joystick takeover, clear/packet collisions, reset and optional recentring.
module tb_mouse_axis_emu;
    import mouse_axis_pkg::*;

    logic clk_sys = 1'b0;
    logic hard_reset_n = 1'b0;
    logic tog = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic signed [7:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;

    mouse_axis_if #(.AXIS_W(8)) bus ();

    mouse_axis_emu #(
        .AXIS_W(8),
        .MAX_STEP(10),
        .INVERT_Y(1)
`ifdef MOUSE_AXIS_RECENTRE_EN
        ,
        .RECENTRE_PERIOD(4)
`endif
    ) dut (
        .clk_sys      (clk_sys),
        .hard_reset_n (hard_reset_n),
        .bus          (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] st);
        tog = ~tog;
        bus.ps2_mouse = {tog, dy, dx, st};
        tick();
    endtask

    task automatic clear_all();
        bus.sync_clear = 1'b1;
        tick();
        bus.sync_clear = 1'b0;
        tick();
    endtask

    initial begin
        bus.ps2_mouse  = '0;
        bus.mouse_en   = 1'b1;
        bus.sync_clear = 1'b0;
        bus.joy_x      = '0;
        bus.joy_y      = '0;
        bus.joy_fire   = 1'b0;
        bus.joy_active = 1'b0;

        // Reset state
        #12;
        check("rst_axis_x", bus.axis_x, 0);
        check("rst_axis_y", bus.axis_y, 0);
        check("rst_fire", bus.fire, 0);
        check("rst_emu", bus.emu_active, 0);
        #10 hard_reset_n = 1'b1;
        tick();

        // First packet: +5 on X, visible two edges after the sampling edge
        send(8'h05, 8'h00, 8'h00);
        check("lat_n_emu", bus.emu_active, 0);
        tick();
        check("lat_n1_x", bus.axis_x, 0);
        tick();
        check("lat_n2_x", bus.axis_x, 5);
        check("lat_n2_emu", bus.emu_active, 1);
        check("lat_n2_y", bus.axis_y, 0);

`ifndef MOUSE_AXIS_RECENTRE_EN
        // Y inversion and left button
        send(8'h00, 8'h05, 8'h01);
        tick(); tick();
        check("invy_y", bus.axis_y, -5);
        check("invy_fire", bus.fire, 1);
        check("invy_x", bus.axis_x, 5);

        // Negative clamp without overflow: -16 -> -10
        send(8'hF0, 8'h00, 8'h10);
        tick(); tick();
        check("negclamp_x", bus.axis_x, -5);
        check("negclamp_fire", bus.fire, 0);

        clear_all();
        check("clr_x", bus.axis_x, 0);
        check("clr_emu", bus.emu_active, 0);

        // 13 back-to-back +100 packets: steps of 10 saturating at 127
        for (int k = 1; k <= 13; k++) exp_q.push_back((10 * k > 127) ? 8'sd127 : 8'(10 * k));
        for (int k = 1; k <= 15; k++) begin
            if (k <= 13) send(8'h64, 8'h00, 8'h00);
            else tick();
            if (k >= 3) check("satpos_x", bus.axis_x, exp_q.pop_front());
        end

        // X overflow with negative sign: -10 per packet, saturating at -128
        clear_all();
        for (int k = 1; k <= 13; k++) exp_q.push_back((-10 * k < -128) ? -8'sd128 : 8'(-10 * k));
        for (int k = 1; k <= 15; k++) begin
            if (k <= 13) send(8'h20, 8'h00, 8'h50);
            else tick();
            if (k >= 3) check("satneg_x", bus.axis_x, exp_q.pop_front());
        end

        // Joystick takeover from MOUSE at 40
        clear_all();
        for (int k = 0; k < 4; k++) send(8'h0A, 8'h00, 8'h00);
        tick(); tick();
        check("joyt_pre_x", bus.axis_x, 40);
        bus.joy_x = -8'sd3;
        bus.joy_active = 1'b1;
        tick();
        check("joyt_emu", bus.emu_active, 0);
        check("joyt_x", bus.axis_x, -3);
        bus.joy_active = 1'b0;
        bus.joy_x = '0;
        tick();
        send(8'h01, 8'h00, 8'h00);
        tick(); tick();
        check("joyt_acc0_x", bus.axis_x, 1);
        check("joyt_acc0_emu", bus.emu_active, 1);

        // sync_clear coinciding with a +7 toggle
        tog = ~tog;
        bus.ps2_mouse = {tog, 8'h00, 8'h07, 8'h00};
        bus.sync_clear = 1'b1;
        tick();
        check("clrpkt_emu", bus.emu_active, 0);
        check("clrpkt_x", bus.axis_x, 0);
        bus.sync_clear = 1'b0;
        tick(); tick(); tick();
        check("clrpkt_late_x", bus.axis_x, 0);
        check("clrpkt_late_emu", bus.emu_active, 0);

        // Clear while the packet is one stage into the pipe
        send(8'h07, 8'h00, 8'h00);
        bus.sync_clear = 1'b1;
        tick();
        bus.sync_clear = 1'b0;
        tick(); tick();
        check("clrs0_x", bus.axis_x, 0);
        check("clrs0_emu", bus.emu_active, 0);

        // Clear while the packet sits in stage 1
        send(8'h07, 8'h00, 8'h00);
        tick();
        bus.sync_clear = 1'b1;
        tick();
        bus.sync_clear = 1'b0;
        tick();
        check("clrs1_x", bus.axis_x, 0);
        check("clrs1_emu", bus.emu_active, 0);

        // mouse_en low forces JOY and ignores packets
        send(8'h03, 8'h00, 8'h00);
        tick(); tick();
        check("men_pre_x", bus.axis_x, 3);
        bus.mouse_en = 1'b0;
        tick();
        check("men_off_emu", bus.emu_active, 0);
        check("men_off_x", bus.axis_x, 0);
        send(8'h04, 8'h00, 8'h00);
        tick(); tick();
        check("men_pkt_emu", bus.emu_active, 0);
        bus.mouse_en = 1'b1;
        tick(); tick(); tick();
        check("men_on_emu", bus.emu_active, 0);
        check("men_on_x", bus.axis_x, 0);

        // Joystick path: one registered cycle
        bus.joy_x = 8'sd17;
        bus.joy_y = -8'sd9;
        bus.joy_fire = 1'b1;
        check("joy_before_x", bus.axis_x, 0);
        tick();
        check("joy_x", bus.axis_x, 17);
        check("joy_y", bus.axis_y, -9);
        check("joy_fire", bus.fire, 1);
        bus.joy_x = '0;
        bus.joy_y = '0;
        bus.joy_fire = 1'b0;
        tick();

        // Reset mid-packet
        send(8'h09, 8'h00, 8'h00);
        #2;
        hard_reset_n = 1'b0;
        tog = 1'b0;
        bus.ps2_mouse = '0;
        #1;
        check("midrst_x", bus.axis_x, 0);
        check("midrst_emu", bus.emu_active, 0);
        @(negedge clk_sys);
        hard_reset_n = 1'b1;
        tick(); tick(); tick();
        check("postrst_x", bus.axis_x, 0);
        check("postrst_emu", bus.emu_active, 0);
`else
        // Recentre: axis_y = 3 decays one LSB every 4 idle cycles
        clear_all();
        send(8'h00, 8'hFD, 8'h20);
        tick(); tick();
        check("rc_start_y", bus.axis_y, 3);
        tick(); tick(); tick();
        check("rc_hold_y", bus.axis_y, 3);
        tick();
        check("rc_step1_y", bus.axis_y, 2);
        repeat (4) tick();
        check("rc_step2_y", bus.axis_y, 1);
        repeat (4) tick();
        check("rc_step3_y", bus.axis_y, 0);
        repeat (8) tick();
        check("rc_hold0_y", bus.axis_y, 0);
        check("rc_emu", bus.emu_active, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
